prefetch_issue_queue: RTL and testbench
=======================================

// Module: prefetch_issue_queue
// PURPOSE
//  Sits directly downstream of the stride prefetcher and upstream of the L2 request port.
//  - Buffers speculative prefetch addresses and aligns them to cache lines.
//  - Drops duplicates against queued lines and recently issued lines.
//  - Issues lines to memory over a valid/ready handshake. Prefetches are droppable, so the
//    upstream side is never back-pressured.
// PARAMETERS
//  ADDR_WIDTH        32  address width, both interfaces
//  CACHE_LINE_BYTES  64  line size, power of 2; OFFSET_BITS = log2
//  QUEUE_DEPTH       4   issue FIFO entries, power of 2, >= 2
//  FILTER_ENTRIES    8   recently-issued line filter entries, >= 1
// PORTS
//  clk_i            in   1           system clock
//  rst_ni           in   1           synchronous active-low reset
//  pf_req_valid_i   in   1           prefetch request from the prefetcher
//  pf_req_ready_o   out  1           always 1 outside reset (requests are accepted or dropped)
//  pf_req_addr_i    in   ADDR_WIDTH  prefetch byte address
//  demand_valid_i   in   1           demand miss observed (used only with PFQ_DEMAND_SQUASH_EN)
//  demand_addr_i    in   ADDR_WIDTH  demand miss byte address
//  flush_i          in   1           discard all queued and filter state
//  mem_req_valid_o  out  1           prefetch issue request to L2
//  mem_req_ready_i  in   1           L2 accepts the request
//  mem_req_addr_o   out  ADDR_WIDTH  line-aligned address; low OFFSET_BITS are 0
//  pf_drop_o        out  1           1-cycle pulse: a valid input request was dropped
//  queue_count_o    out  log2(QUEUE_DEPTH)+1  occupied entries, live and dead
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge):
//   - queue empty, all filter entries invalid, pointers 0.
//   - mem_req_valid_o=0, mem_req_addr_o=0, pf_drop_o=0, queue_count_o=0.
//   - pf_req_ready_o=0 while rst_ni=0.
//   - Reset mid-handshake abandons the request with no drain.
//  Line address: line(a) = a[ADDR_WIDTH-1:OFFSET_BITS]. All compares use line addresses only.
//  Accept: a valid request is pushed unless one of the following holds; otherwise it is
//  dropped and pf_drop_o pulses the next cycle:
//   (a) its line matches any occupied queue entry, head included;
//   (b) its line matches any valid filter entry;
//   (c) the queue is full and no pop happens this cycle;
//   (d) flush_i=1.
//  Full plus pop in the same cycle: the push is accepted.
//  Latency: an entry accepted in cycle N can assert mem_req_valid_o in cycle N+1. No bypass.
//  Issue:
//   - mem_req_valid_o = queue non-empty and head entry live.
//   - The address stays stable while valid=1 and ready=0.
//   - On a handshake, the head pops and line(head) is written into the filter in the same cycle.
//  Dead head (non-live): popped silently in one cycle with mem_req_valid_o=0, no filter write.
//  Filter:
//   - Circular replacement pointer wraps modulo FILTER_ENTRIES; the oldest entry is overwritten.
//   - Entries never age out except by overwrite or flush.
//  Flush: at the next edge, queue and filter are cleared and pointers are zeroed.
//   - Same-cycle inputs are dropped; a same-cycle handshake still counts as issued.
//   - Flush may abort a pending un-accepted request; this is the only handshake break.
//  Pointers: read/write pointers wrap at QUEUE_DEPTH; an extra bit distinguishes full from empty.
// CONFIGURATION
//  PFQ_DEMAND_SQUASH_EN defined:
//   - demand_valid_i=1 marks every occupied non-head entry with line == line(demand_addr_i)
//     as dead at the next edge.
//   - The head is never squashed because it may be mid-handshake.
//   - A same-cycle pf request to that line is dropped and pulses pf_drop_o.
//  PFQ_DEMAND_SQUASH_EN undefined: demand_* are ignored and all entries stay live.
// STRUCTURE
//  prefetch_pkg:
//   - pfq_entry_t {live, line_addr}
//   - function line_of(addr)
//   - localparam computation of OFFSET_BITS
//  Sub-module pfq_recent_filter:
//   - FILTER_ENTRIES line CAM with a valid bit per entry.
//   - Ports: insert, lookup-hit, flush, circular pointer.
//  Top level holds the FIFO, drop logic and squash logic.
// TESTING
//  1. Reset then idle -> all outputs 0 and pf_req_ready_o=1.
//     Push 0x1004, ready=1 -> next cycle mem_req_addr_o=0x1000, valid=1.
//  2. Push 0x2000 then 0x2030 (same line) -> one issue of 0x2000; second request pf_drop_o=1.
//  3. mem_req_ready_i=0, push 0x3000,0x3040,0x3080,0x30C0,0x3100 ->
//     count=4, 5th dropped, head 0x3000 stable. Release ready -> issue order 0x3000..0x30C0.
//  4. Issue 0x4000, then re-push 0x4000 -> dropped (filter hit).
//     After 8 distinct issued lines, 0x4000 is accepted again.
//  5. Queue with 3 entries, flush_i=1 with pf valid 0x5000 -> next cycle count=0, valid=0,
//     drop pulse. Re-push of a previously issued line is accepted.
//  6. (PFQ_DEMAND_SQUASH_EN) Queue 0x6000(head),0x6040,0x6080 with ready=0, demand 0x6044 ->
//     0x6040 marked dead. With ready=1: issue 0x6000, one idle cycle, then 0x6080.

Source files
------------

// File: rtl/prefetch_issue_queue_pkg.sv
// Shared types and helpers for the prefetch issue queue slice.
// Line geometry is fixed here; the queue entry carries a live bit so that
// demand-squashed entries can be skipped without compacting the FIFO.
package prefetch_pkg;

    localparam int unsigned PFQ_ADDR_WIDTH = 32;
    localparam int unsigned PFQ_LINE_BYTES = 64;
    localparam int unsigned OFFSET_BITS    = $clog2(PFQ_LINE_BYTES);
    localparam int unsigned LINE_WIDTH     = PFQ_ADDR_WIDTH - OFFSET_BITS;

    typedef logic [LINE_WIDTH-1:0] line_addr_t;

    typedef struct packed {
        logic       live;
        line_addr_t line_addr;
    } pfq_entry_t;

    function automatic line_addr_t line_of(input logic [PFQ_ADDR_WIDTH-1:0] addr);
        return addr[PFQ_ADDR_WIDTH-1:OFFSET_BITS];
    endfunction

endpackage

// File: rtl/prefetch_issue_queue_filter.sv
// Recently-issued line filter: small CAM of line addresses with a valid bit
// per entry. New lines overwrite the oldest slot via a circular pointer;
// entries only disappear through overwrite or flush.
module pfq_recent_filter
    import prefetch_pkg::*;
#(
    parameter int unsigned FILTER_ENTRIES = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       insert_i,
    input  line_addr_t insert_line_i,
    input  line_addr_t lookup_line_i,
    output logic       hit_o
);

    localparam int unsigned PTR_W = (FILTER_ENTRIES > 1) ? $clog2(FILTER_ENTRIES) : 1;

    logic [FILTER_ENTRIES-1:0] valid_q;
    line_addr_t                line_q [FILTER_ENTRIES];
    logic [PTR_W-1:0]          ptr_q;

    // Associative lookup across every valid slot.
    always_comb begin
        hit_o = 1'b0;
        for (int unsigned i = 0; i < FILTER_ENTRIES; i++) begin
            if (valid_q[i] && (line_q[i] == lookup_line_i)) begin
                hit_o = 1'b1;
            end
        end
    end

    // Insert at the replacement pointer, wrapping modulo FILTER_ENTRIES; flush clears all.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            valid_q <= '0;
            ptr_q   <= '0;
            for (int unsigned i = 0; i < FILTER_ENTRIES; i++) begin
                line_q[i] <= '0;
            end
        end else if (insert_i) begin
            valid_q[ptr_q] <= 1'b1;
            line_q[ptr_q]  <= insert_line_i;
            ptr_q          <= (ptr_q == PTR_W'(FILTER_ENTRIES - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

endmodule

// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: buffers line-aligned prefetch addresses, drops
// duplicates against queued and recently issued lines, and issues them to
// L2 over valid/ready. Upstream is never back-pressured; rejected requests
// pulse pf_drop_o one cycle later.
// Optional feature macro: PFQ_DEMAND_SQUASH_EN (demand misses kill matching
// non-head queue entries).
module prefetch_issue_queue
    import prefetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = PFQ_ADDR_WIDTH,
    parameter int unsigned CACHE_LINE_BYTES = PFQ_LINE_BYTES,
    parameter int unsigned QUEUE_DEPTH      = 4,
    parameter int unsigned FILTER_ENTRIES   = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           pf_req_valid_i,
    output logic                           pf_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]          pf_req_addr_i,
    input  logic                           demand_valid_i,
    input  logic [ADDR_WIDTH-1:0]          demand_addr_i,
    input  logic                           flush_i,
    output logic                           mem_req_valid_o,
    input  logic                           mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
    output logic                           pf_drop_o,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count_o
);

    localparam int unsigned OFF_W = $clog2(CACHE_LINE_BYTES);
    localparam int unsigned IDX_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    pfq_entry_t               q_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q, count;
    logic [IDX_W-1:0]         rd_idx, wr_idx;
    logic [QUEUE_DEPTH-1:0]   occ, q_match, squash_mask;
    pfq_entry_t               head;
    line_addr_t               pf_line;
    logic                     empty, full, pop, handshake;
    logic                     filter_hit, squash_hit, drop, push;
    logic                     pf_drop_q;

    assign pf_line   = line_of(pf_req_addr_i);
    assign rd_idx    = rd_ptr_q[IDX_W-1:0];
    assign wr_idx    = wr_ptr_q[IDX_W-1:0];
    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (count == '0);
    assign full      = (count == PTR_W'(QUEUE_DEPTH));
    assign head      = q_mem[rd_idx];

    assign mem_req_valid_o = !empty && head.live;
    assign mem_req_addr_o  = {head.line_addr, {OFF_W{1'b0}}};
    assign handshake       = mem_req_valid_o && mem_req_ready_i;
    // Dead heads retire on their own; live heads need the L2 handshake.
    assign pop             = !empty && (!head.live || mem_req_ready_i);

    assign pf_req_ready_o  = rst_ni;
    assign pf_drop_o       = pf_drop_q;
    assign queue_count_o   = count;

    // Occupancy per slot (distance from head below count) and duplicate match against the request.
    always_comb begin
        logic [IDX_W-1:0] offs;
        offs    = '0;
        occ     = '0;
        q_match = '0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            offs       = IDX_W'(i) - rd_idx;
            occ[i]     = ({1'b0, offs} < count);
            q_match[i] = occ[i] && (q_mem[i].line_addr == pf_line);
        end
    end

`ifdef PFQ_DEMAND_SQUASH_EN
    line_addr_t demand_line;
    assign demand_line = line_of(demand_addr_i);
    assign squash_hit  = demand_valid_i && (demand_line == pf_line);

    // Mark occupied non-head entries matching the demand line; the head may be mid-handshake.
    always_comb begin
        squash_mask = '0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            squash_mask[i] = demand_valid_i && occ[i] && (IDX_W'(i) != rd_idx)
                             && (q_mem[i].line_addr == demand_line);
        end
    end
`else
    logic unused_demand;
    assign unused_demand = ^{demand_valid_i, demand_addr_i};
    assign squash_hit    = 1'b0;
    assign squash_mask   = '0;
`endif

    assign drop = pf_req_valid_i && ((|q_match) || filter_hit || (full && !pop) || flush_i || squash_hit);
    assign push = pf_req_valid_i && !drop;

    // FIFO storage and pointers; flush zeroes pointers while a same-cycle handshake still completes downstream.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                if (squash_mask[i]) begin
                    q_mem[i].live <= 1'b0;
                end
            end
            if (push) begin
                q_mem[wr_idx] <= '{live: 1'b1, line_addr: pf_line};
                wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Registered drop pulse, one cycle after the rejected request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pf_drop_q <= 1'b0;
        end else begin
            pf_drop_q <= drop;
        end
    end

    pfq_recent_filter #(
        .FILTER_ENTRIES (FILTER_ENTRIES)
    ) u_filter (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .insert_i       (handshake),
        .insert_line_i  (head.line_addr),
        .lookup_line_i  (pf_line),
        .hit_o          (filter_hit)
    );

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Directed bench for prefetch_issue_queue. Inputs change 1ns after each
// rising edge; outputs are checked at that same point, before inputs move.
// Step 6 expectations depend on PFQ_DEMAND_SQUASH_EN.
module tb_prefetch_issue_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        pf_req_valid_i;
    logic        pf_req_ready_o;
    logic [31:0] pf_req_addr_i;
    logic        demand_valid_i;
    logic [31:0] demand_addr_i;
    logic        flush_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        pf_drop_o;
    logic [2:0]  queue_count_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    prefetch_issue_queue #(
        .ADDR_WIDTH       (32),
        .CACHE_LINE_BYTES (64),
        .QUEUE_DEPTH      (4),
        .FILTER_ENTRIES   (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .pf_req_valid_i  (pf_req_valid_i),
        .pf_req_ready_o  (pf_req_ready_o),
        .pf_req_addr_i   (pf_req_addr_i),
        .demand_valid_i  (demand_valid_i),
        .demand_addr_i   (demand_addr_i),
        .flush_i         (flush_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .pf_drop_o       (pf_drop_o),
        .queue_count_o   (queue_count_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        pf_req_valid_i = 1'b1;
        pf_req_addr_i  = a;
        tick();
        pf_req_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni          = 1'b0;
        pf_req_valid_i  = 1'b0;
        pf_req_addr_i   = '0;
        demand_valid_i  = 1'b0;
        demand_addr_i   = '0;
        flush_i         = 1'b0;
        mem_req_ready_i = 1'b0;
        #1;
        chk("ready_in_reset", 32'(pf_req_ready_o), 0);
        tick();
        tick();
        chk("rst_valid", 32'(mem_req_valid_o), 0);
        chk("rst_addr",  mem_req_addr_o, 0);
        chk("rst_drop",  32'(pf_drop_o), 0);
        chk("rst_count", 32'(queue_count_o), 0);
        rst_ni = 1'b1;
        #1;
        chk("ready_after_reset", 32'(pf_req_ready_o), 1);

        // 1: basic push and alignment
        mem_req_ready_i = 1'b1;
        push(32'h1004);
        chk("t1_valid", 32'(mem_req_valid_o), 1);
        chk("t1_addr",  mem_req_addr_o, 32'h1000);
        chk("t1_count", 32'(queue_count_o), 1);
        tick();
        chk("t1_idle_valid", 32'(mem_req_valid_o), 0);
        chk("t1_idle_count", 32'(queue_count_o), 0);

        // 2: same-line duplicate against queued head
        push(32'h2000);
        chk("t2_addr", mem_req_addr_o, 32'h2000);
        push(32'h2030);
        chk("t2_drop",  32'(pf_drop_o), 1);
        chk("t2_valid", 32'(mem_req_valid_o), 0);
        chk("t2_count", 32'(queue_count_o), 0);

        // 3: full queue, 5th dropped, then full+pop push accepted
        mem_req_ready_i = 1'b0;
        push(32'h3000);
        push(32'h3040);
        push(32'h3080);
        push(32'h30C0);
        chk("t3_no_drop", 32'(pf_drop_o), 0);
        push(32'h3100);
        chk("t3_count_full", 32'(queue_count_o), 4);
        chk("t3_drop_full",  32'(pf_drop_o), 1);
        chk("t3_head_stable", mem_req_addr_o, 32'h3000);
        chk("t3_head_valid", 32'(mem_req_valid_o), 1);
        mem_req_ready_i = 1'b1;
        push(32'h3100);
        chk("t3_full_pop_drop", 32'(pf_drop_o), 0);
        chk("t3_full_pop_count", 32'(queue_count_o), 4);
        chk("t3_issue1", mem_req_addr_o, 32'h3040);
        tick();
        chk("t3_issue2", mem_req_addr_o, 32'h3080);
        tick();
        chk("t3_issue3", mem_req_addr_o, 32'h30C0);
        tick();
        chk("t3_issue4", mem_req_addr_o, 32'h3100);
        tick();
        chk("t3_drained", 32'(queue_count_o), 0);

        // 4: filter hit, then eviction after 8 newer issues
        push(32'h4000);
        chk("t4_addr", mem_req_addr_o, 32'h4000);
        tick();
        push(32'h4000);
        chk("t4_filter_drop", 32'(pf_drop_o), 1);
        chk("t4_filter_count", 32'(queue_count_o), 0);
        for (int k = 1; k <= 8; k++) begin
            push(32'h4000 + 32'(k) * 32'h40);
        end
        chk("t4_last_no_drop", 32'(pf_drop_o), 0);
        tick();
        push(32'h4000);
        chk("t4_evicted_drop", 32'(pf_drop_o), 0);
        chk("t4_evicted_addr", mem_req_addr_o, 32'h4000);
        tick();

        // 5: flush with a same-cycle request
        mem_req_ready_i = 1'b0;
        push(32'h5040);
        push(32'h5080);
        push(32'h50C0);
        chk("t5_count3", 32'(queue_count_o), 3);
        flush_i = 1'b1;
        push(32'h5000);
        flush_i = 1'b0;
        chk("t5_flush_count", 32'(queue_count_o), 0);
        chk("t5_flush_valid", 32'(mem_req_valid_o), 0);
        chk("t5_flush_drop",  32'(pf_drop_o), 1);
        mem_req_ready_i = 1'b1;
        push(32'h4000);
        chk("t5_repush_drop", 32'(pf_drop_o), 0);
        chk("t5_repush_addr", mem_req_addr_o, 32'h4000);
        tick();

        // 6: demand squash of a non-head entry
        mem_req_ready_i = 1'b0;
        push(32'h6000);
        push(32'h6040);
        push(32'h6080);
        demand_valid_i = 1'b1;
        demand_addr_i  = 32'h6044;
        push(32'h6050);
        demand_valid_i = 1'b0;
        chk("t6_drop", 32'(pf_drop_o), 1);
        chk("t6_count", 32'(queue_count_o), 3);
        mem_req_ready_i = 1'b1;
        chk("t6_head", mem_req_addr_o, 32'h6000);
        tick();
`ifdef PFQ_DEMAND_SQUASH_EN
        chk("t6_dead_valid", 32'(mem_req_valid_o), 0);
        chk("t6_dead_count", 32'(queue_count_o), 2);
        tick();
`else
        chk("t6_live_addr", mem_req_addr_o, 32'h6040);
        chk("t6_live_valid", 32'(mem_req_valid_o), 1);
        tick();
`endif
        chk("t6_last_addr", mem_req_addr_o, 32'h6080);
        chk("t6_last_valid", 32'(mem_req_valid_o), 1);
        tick();
        chk("t6_drained", 32'(queue_count_o), 0);

        // 7: reset mid-handshake abandons the request
        mem_req_ready_i = 1'b0;
        push(32'h7000);
        chk("t7_pending", 32'(mem_req_valid_o), 1);
        rst_ni = 1'b0;
        tick();
        chk("t7_rst_valid", 32'(mem_req_valid_o), 0);
        chk("t7_rst_count", 32'(queue_count_o), 0);
        chk("t7_rst_ready", 32'(pf_req_ready_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
